sha256_compress: RTL
====================

SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_word carries a valid message word.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_word  input  32  message word, big-endian word order, W0 first.
REQ-007 in_first  input  1  with word 0 only: start a new message and load the IV into H.
REQ-008 out_valid  output  1  out_hash holds the chaining value for the last block.
REQ-009 out_ready  input  1  consumer takes out_hash.
REQ-010 out_hash  output  256  H0..H7, with H0 in bits [255:224].

Function
REQ-011 A transfer SHALL occur on any cycle where in_valid and in_ready are both 1. An output handshake SHALL occur on any cycle where out_valid and out_ready are both 1.
REQ-012 FSM states SHALL be LOAD, ROUND, FINAL and DONE; reset state is LOAD.
REQ-013 LOAD: in_ready=1; each transfer SHALL write the word into W[wcnt] and increment the 4-bit wcnt. The transfer at wcnt=15 SHALL move to ROUND, clear rcnt, and set a..h from H.
REQ-014 in_first SHALL be sampled only on the transfer at wcnt=0; if 1, H SHALL be loaded with the IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 in that same cycle.
REQ-015 in_first SHALL be ignored on transfers at wcnt 1..15.
REQ-016 ROUND: one round per cycle for rcnt=0..63, with in_ready=0.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[rcnt] + Wt; T2 = Σ0(a) + Maj(a,b,c).
  - All additions mod 2^32.
REQ-017 Σ0 SHALL be rotr2^rotr13^rotr22 and Σ1 SHALL be rotr6^rotr11^rotr25. σ0 SHALL be rotr7^rotr18^shr3 and σ1 SHALL be rotr17^rotr19^shr10.
REQ-018 Wt SHALL come from a 16-entry sliding window. For rcnt<16, Wt=W[rcnt]. For rcnt>=16, Wt = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], and the window shifts by one each cycle.
REQ-019 K[0..63] SHALL be the FIPS 180-4 constants, held in a combinational ROM indexed by rcnt.
REQ-020 Round update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
REQ-021 After the round with rcnt=63 the block SHALL enter FINAL. FINAL SHALL perform Hi <= Hi + working variable i (mod 2^32) for all i, then enter DONE.
REQ-022 DONE: out_valid=1 and out_hash=H, held stable until the output handshake. On the handshake the block SHALL enter LOAD with wcnt=0.
REQ-023 While out_valid=1 and out_ready=0, out_hash and all state SHALL be frozen, and in_ready SHALL be 0.
REQ-024 out_valid SHALL be 0 in LOAD, ROUND and FINAL.
REQ-025 in_ready SHALL be 1 only in LOAD.
REQ-026 Latency: if the 16th word transfers in cycle N, out_valid SHALL first be 1 in cycle N+66 (64 ROUND cycles, then FINAL, then DONE).
REQ-027 Chaining: a block whose word 0 has in_first=0 SHALL start from the H left by the previous block.
REQ-028 The block SHALL NOT pad messages.
REQ-029 wcnt and rcnt SHALL reach their end values without overflow. wcnt wraps 15->0 only on the transition to ROUND.

Reset
REQ-030 While rst_n=0, all of the following SHALL hold immediately, without waiting for a clock edge: state=LOAD, wcnt=0, rcnt=0, out_valid=0, in_ready=0, H=IV, a..h=0, W=0.
REQ-031 out_hash SHALL read as the IV during reset.
REQ-032 in_ready SHALL return to 1 on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-LOAD, mid-ROUND or in DONE SHALL discard the partial block and any pending output. No out_valid pulse SHALL follow.

Verification
REQ-034 "abc": words 61626380, 14x 00000000, 00000018, in_first=1 -> out_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid exactly 66 cycles after word 15.
REQ-035 Empty message: 80000000, 15x 00000000, in_first=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-036 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (padded): block 2 with in_first=0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-037 "abc" sent twice, both with in_first=1, with out_ready=0 for 10 cycles on the first result -> out_hash stable and in_ready=0 throughout; both results equal the REQ-034 digest.
REQ-038 Random in_valid gaps during LOAD, and in_first=1 driven on word 7 -> digest identical to REQ-034.
REQ-039 rst_n pulsed low at rcnt=30 -> out_valid=0 and out_hash=IV at once; a following "abc" block yields the REQ-034 digest.

Source files
------------

// File: rtl/sha256_compress.sv
// sha256_compress
//
// SHA-256 compression engine: accepts one 512-bit message block as sixteen
// 32-bit words, runs the 64 compression rounds one per cycle, folds the
// working variables into the chaining value and presents the updated H.
// The block does no padding; the caller supplies fully padded blocks.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_word carries a valid message word
//   in_ready   block accepts a word this cycle (LOAD only)
//   in_word    message word, W0 first
//   in_first   with word 0 only: restart the chain from the IV
//   out_valid  out_hash holds the chaining value for the last block
//   out_ready  consumer takes out_hash
//   out_hash   H0..H7, H0 in bits [255:224]

module sha256_compress (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_hash
);

    typedef enum logic [1:0] {LOAD, ROUND, FINAL, DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bigSigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bigSigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] smallSigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] smallSigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [5:0]  rcnt_q, rcnt_d;
    logic        readyEn_q;
    logic [31:0] hash_q [8];
    logic [31:0] hash_d [8];
    // work_q[0..7] are the working variables a..h
    logic [31:0] work_q [8];
    logic [31:0] work_d [8];
    // message schedule window; during rounds >= 16 it holds W[t-16..t-1]
    logic [31:0] win_q  [16];
    logic [31:0] win_d  [16];

    logic [31:0] wt;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        inXfer;

    // in_ready only comes up one edge after reset releases, so the first
    // cycle out of reset never accepts a word.
    assign in_ready  = readyEn_q && (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign out_hash  = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                        hash_q[4], hash_q[5], hash_q[6], hash_q[7]};
    assign inXfer    = in_valid && in_ready;

    // Round datapath: first sixteen rounds read the loaded words directly,
    // later rounds expand the schedule from the sliding window.
    always_comb begin
        if (rcnt_q < 6'd16) begin
            wt = win_q[rcnt_q[3:0]];
        end else begin
            wt = smallSigma1(win_q[14]) + win_q[9] + smallSigma0(win_q[1]) + win_q[0];
        end
        t1 = work_q[7] + bigSigma1(work_q[4])
           + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
           + K_ROM[rcnt_q] + wt;
        t2 = bigSigma0(work_q[0])
           + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
    end

    // Next-state logic for the FSM and all datapath registers. Everything
    // holds by default, which is what freezes the block in DONE while the
    // consumer stalls.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        hash_d  = hash_q;
        work_d  = work_q;
        win_d   = win_q;

        unique case (state_q)
            LOAD: begin
                if (inXfer) begin
                    win_d[wcnt_q] = in_word;
                    wcnt_d        = wcnt_q + 4'd1;
                    if ((wcnt_q == 4'd0) && in_first) begin
                        hash_d = IV;
                    end
                    if (wcnt_q == 4'd15) begin
                        state_d = ROUND;
                        rcnt_d  = 6'd0;
                        work_d  = hash_q;
                    end
                end
            end
            ROUND: begin
                work_d[7] = work_q[6];
                work_d[6] = work_q[5];
                work_d[5] = work_q[4];
                work_d[4] = work_q[3] + t1;
                work_d[3] = work_q[2];
                work_d[2] = work_q[1];
                work_d[1] = work_q[0];
                work_d[0] = t1 + t2;
                if (rcnt_q >= 6'd16) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = wt;
                end
                if (rcnt_q == 6'd63) begin
                    state_d = FINAL;
                end else begin
                    rcnt_d = rcnt_q + 6'd1;
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    hash_d[i] = hash_q[i] + work_q[i];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = LOAD;
                    wcnt_d  = 4'd0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State registers. Reset drops any partial block or pending result and
    // restarts the chain from the IV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            wcnt_q    <= 4'd0;
            rcnt_q    <= 6'd0;
            readyEn_q <= 1'b0;
            hash_q    <= IV;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            readyEn_q <= 1'b1;
            hash_q    <= hash_d;
            work_q    <= work_d;
            win_q     <= win_d;
        end
    end

endmodule
